bcd_timer_counter: RTL and testbench

Parametrised multi-digit BCD up/down counter with built-in prescaler, terminal-count detection and selectable wrap/hold mode. Generalises the single-digit decimal counter to DIGITS cascaded decades behind one enable and one direction control. Sits in the timer datapath between the free-running clock and the display/compare logic. It also serves as a stopwatch or countdown core.

---
 rtl/bcd_timer_counter.sv | 144 ++++++++++++++
 tb/tb_bcd_timer_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_counter.sv
// Multi-decade BCD up/down counter with prescaler, terminal detection and wrap/hold.
// Every count digit stays in 0..9; loads are clamped to BCD on the way in.
module bcd_timer_counter #(
    parameter int DIGITS   = 2,
    parameter int TICK_DIV = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] i_init,
    input  logic                i_init_vld,
    input  logic                i_enable,
    input  logic                i_count_down,
    input  logic                i_wrap,
    output logic [4*DIGITS-1:0] o_value,
    output logic                o_carry,
    output logic                o_terminal
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [W-1:0]  value_r;
    logic [W-1:0]  value_nxt_s;
    logic [PW-1:0] presc_r;
    logic [PW-1:0] presc_nxt_s;
    logic          carry_r;
    logic          carry_nxt_s;
    logic          presc_last_s;
    logic          term_s;

    // Clamp every digit of a load value to at most 9.
    function automatic logic [W-1:0] clamp_bcd(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] > 4'd9) begin
                r[4*d +: 4] = 4'd9;
            end else begin
                r[4*d +: 4] = v[4*d +: 4];
            end
        end
        return r;
    endfunction

    // One BCD step with ripple across decades; at the terminal this naturally wraps.
    function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic down);
        logic [W-1:0] r;
        logic [3:0]   digit;
        logic         prop;
        r    = v;
        prop = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            digit = v[4*d +: 4];
            if (!prop) begin
                r[4*d +: 4] = digit;
            end else if (down) begin
                if (digit == 4'd0) begin
                    r[4*d +: 4] = 4'd9;
                end else begin
                    r[4*d +: 4] = digit - 4'd1;
                    prop        = 1'b0;
                end
            end else begin
                if (digit >= 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = digit + 4'd1;
                    prop        = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // True when every digit equals the terminal digit for the current direction.
    function automatic logic is_terminal(input logic [W-1:0] v, input logic down);
        logic       res;
        logic [3:0] tgt;
        tgt = down ? 4'd0 : 4'd9;
        res = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (v[4*d +: 4] != tgt) begin
                res = 1'b0;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Terminal detection and prescaler wrap point.
    always_comb begin
        presc_last_s = (presc_r == PRESC_LAST);
        term_s       = is_terminal(value_r, i_count_down);
    end

    // Next-state selection: load beats enable beats hold.
    always_comb begin
        value_nxt_s = value_r;
        presc_nxt_s = presc_r;
        carry_nxt_s = 1'b0;
        if (i_init_vld) begin
            value_nxt_s = clamp_bcd(i_init);
            presc_nxt_s = '0;
        end else if (i_enable) begin
            if (presc_last_s) begin
                presc_nxt_s = '0;
                if (term_s) begin
                    carry_nxt_s = 1'b1;
                    if (i_wrap) begin
                        value_nxt_s = bcd_step(value_r, i_count_down);
                    end else begin
                        value_nxt_s = value_r;
                    end
                end else begin
                    value_nxt_s = bcd_step(value_r, i_count_down);
                end
            end else begin
                presc_nxt_s = presc_r + PW'(1);
            end
        end else begin
            value_nxt_s = value_r;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_r <= '0;
            presc_r <= '0;
            carry_r <= 1'b0;
        end else begin
            value_r <= value_nxt_s;
            presc_r <= presc_nxt_s;
            carry_r <= carry_nxt_s;
        end
    end

    assign o_value    = value_r;
    assign o_carry    = carry_r;
    assign o_terminal = term_s;

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed bench: vector table on a TICK_DIV=1 instance, hand sequences on a TICK_DIV=3 instance.
module tb_bcd_timer_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] init = 8'h00;
    logic       init_vld = 1'b0;
    logic       enable = 1'b0;
    logic       count_down = 1'b0;
    logic       wrap = 1'b0;

    logic [7:0] value1, value3;
    logic       carry1, carry3, term1, term3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bcd_timer_counter #(.DIGITS(2), .TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_init(init), .i_init_vld(init_vld),
        .i_enable(enable), .i_count_down(count_down), .i_wrap(wrap),
        .o_value(value1), .o_carry(carry1), .o_terminal(term1)
    );

    bcd_timer_counter #(.DIGITS(2), .TICK_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_init(init), .i_init_vld(init_vld),
        .i_enable(enable), .i_count_down(count_down), .i_wrap(wrap),
        .o_value(value3), .o_carry(carry3), .o_terminal(term3)
    );

    typedef struct {
        logic       vld;
        logic [7:0] init;
        logic       en;
        logic       down;
        logic       wrap;
        logic [7:0] ev;
        logic       ec;
        logic       et;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic vld, input logic [7:0] ini, input logic en,
                                input logic dn, input logic wr, input logic [7:0] ev,
                                input logic ec, input logic et);
        vec_t v;
        v.vld = vld; v.init = ini; v.en = en; v.down = dn; v.wrap = wr;
        v.ev = ev; v.ec = ec; v.et = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [7:0] ini, input logic en);
        init_vld = vld;
        init     = ini;
        enable   = en;
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string name, input logic [7:0] ev, input logic ec, input logic et);
        check({name, "_value"}, value3, ev);
        check({name, "_carry"}, {7'd0, carry3}, {7'd0, ec});
        check({name, "_term"}, {7'd0, term3}, {7'd0, et});
    endtask

    initial begin
        // vld init en down wrap | value carry term
        vecs.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h09, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0));
        // up wrap through 99
        vecs.push_back(mk(1'b1, 8'h98, 1'b0, 1'b0, 1'b1, 8'h98, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0));
        // down hold at 00, then wrap
        vecs.push_back(mk(1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h99, 1'b1, 1'b0));
        // clamped load with enable high, no step that cycle
        vecs.push_back(mk(1'b1, 8'hAF, 1'b1, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h99, 1'b1, 1'b1));
        vecs.push_back(mk(1'b1, 8'hA4, 1'b1, 1'b0, 1'b0, 8'h94, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h45, 1'b1, 1'b0, 1'b0, 8'h45, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0));
        // down across a decade
        vecs.push_back(mk(1'b1, 8'h10, 1'b0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0));

        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_value", value1, 8'h00);
        check("rst_carry", {7'd0, carry1}, 8'h00);
        check("rst_term_up", {7'd0, term1}, 8'h00);
        count_down = 1'b1;
        #1;
        check("rst_term_down", {7'd0, term1}, 8'h01);
        count_down = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // table on TICK_DIV=1
        for (int i = 0; i < vecs.size(); i++) begin
            count_down = vecs[i].down;
            wrap       = vecs[i].wrap;
            drive(vecs[i].vld, vecs[i].init, vecs[i].en);
            check($sformatf("vec%0d_value", i), value1, vecs[i].ev);
            check($sformatf("vec%0d_carry", i), {7'd0, carry1}, {7'd0, vecs[i].ec});
            check($sformatf("vec%0d_term", i), {7'd0, term1}, {7'd0, vecs[i].et});
        end

        // TICK_DIV=3: disabled cycles stretch the spacing
        count_down = 1'b0;
        wrap       = 1'b0;
        drive(1'b1, 8'h00, 1'b0);
        check3("p3_load", 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check3("p3_en1", 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check3("p3_en2", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, 1'b0);
            check3($sformatf("p3_dis%0d", i), 8'h00, 1'b0, 1'b0);
        end
        drive(1'b0, 8'h00, 1'b1);
        check3("p3_step", 8'h01, 1'b0, 1'b0);

        // back-to-back loads keep the prescaler at 0
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h20, 1'b1);
        drive(1'b1, 8'h30, 1'b1);
        check3("b2b_load", 8'h30, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check3("b2b_en2", 8'h30, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check3("b2b_step", 8'h31, 1'b0, 1'b0);

        // carry on TICK_DIV=3 at the up terminal, hold mode
        drive(1'b1, 8'h99, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check3("p3_term_wait", 8'h99, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check3("p3_term_step", 8'h99, 1'b1, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check3("p3_term_after", 8'h99, 1'b0, 1'b1);

        // asynchronous reset mid-count with prescaler at 2
        drive(1'b1, 8'h56, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check3("ar_step", 8'h57, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check3("ar_presc2", 8'h57, 1'b0, 1'b0);
        enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check3("ar_async", 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check3("ar_en2", 8'h00, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check3("ar_first_step", 8'h01, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
